// File: rtl/arb_pkt_pkg.sv
// Shared types and helpers for the packet-level arbiter mux (arb_pkt_mux).
package arb_pkt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Index of the lowest set bit; zero input maps to index 0.
  function automatic int oh2idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--)
      if (oh[i]) idx = i;
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/arb_pkt_oreg.sv
// Single valid/ready register stage carrying W data bits plus end-of-packet.
module arb_pkt_oreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ld,
  input  logic [W-1:0] ld_data,
  input  logic         ld_last,
  input  logic         m_ready,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  output logic         m_last,
  output logic         free
);

  logic         vld_p1;
  logic [W-1:0] data_p1;
  logic         last_p1;

  // Stage p1: load on accept (drain may coincide), else hold until drained.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (ld) begin
      vld_p1  <= 1'b1;
      data_p1 <= ld_data;
      last_p1 <= ld_last;
    end else if (m_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign free    = !vld_p1 || m_ready;
  assign m_valid = vld_p1;
  assign m_data  = data_p1;
  assign m_last  = last_p1;

endmodule

// File: rtl/arb_pkt_mux.sv
// Packet-level N:1 mux around mtx_arb: locks one source per packet, rotates on last.
// Optional lock watchdog enabled by defining ARB_PKT_MUX_TIMEOUT_EN.
module arb_pkt_mux
  import arb_pkt_pkg::*;
#(
  parameter int N       = 3,
  parameter int W       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   s_valid,
  output logic [N-1:0]   s_ready,
  input  logic [N*W-1:0] s_data,
  input  logic [N-1:0]   s_last,
  output logic [N-1:0]   arb_req,
  input  logic [N-1:0]   arb_gnt,
  output logic           arb_upd,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [W-1:0]   m_data,
  output logic           m_last,
  output logic           err_to
);

  localparam int BW = (N * W > 1) ? $clog2(N * W) : 1;

  state_t        state, state_nxt;
  logic [N-1:0]  sel, sel_nxt;
  logic          armed;
  logic          oreg_free;
  logic          src_vld, src_last;
  logic          accept, acc_last, release_to, grant_ok;
  logic [BW-1:0] base;
  logic [W-1:0]  ld_data;

  assign src_vld  = |(s_valid & sel);
  assign src_last = |(s_last & sel);
  assign accept   = (state == LOCK) && src_vld && oreg_free;
  assign acc_last = accept && src_last;
  // armed keeps arb_req low while reset is asserted and for the first edge after it.
  assign grant_ok = armed && is_onehot(32'(arb_gnt));
  assign base     = BW'(oh2idx(32'(sel)) * W);
  assign ld_data  = s_data[base +: W];

`ifdef ARB_PKT_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;
  logic          err_q;

  // A last beat accepted in the expiry cycle releases normally and wins.
  assign release_to = (state == LOCK) && (to_cnt == CW'(TIMEOUT)) && !acc_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state != LOCK || accept)
        to_cnt <= '0;
      else if (!src_vld && to_cnt != CW'(TIMEOUT))
        to_cnt <= to_cnt + CW'(1);
      if (release_to)
        err_q <= 1'b1;
    end
  end

  assign err_to = err_q;
`else
  assign release_to = 1'b0;
  assign err_to     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      sel   <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (grant_ok) begin
          state_nxt = LOCK;
          sel_nxt   = arb_gnt;
        end
      end
      LOCK: begin
        if (acc_last || release_to) begin
          state_nxt = IDLE;
          sel_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    arb_req = '0;
    s_ready = '0;
    arb_upd = 1'b0;
    case (state)
      IDLE: arb_req = armed ? s_valid : '0;
      LOCK: begin
        arb_req = sel;
        s_ready = sel & {N{oreg_free}};
        arb_upd = acc_last || release_to;
      end
      default: ;
    endcase
  end

  arb_pkt_oreg #(.W(W)) u_oreg (
    .clk     (clk),
    .rstn    (rstn),
    .ld      (accept),
    .ld_data (ld_data),
    .ld_last (src_last),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .free    (oreg_free)
  );

endmodule

// File: tb/tb_arb_pkt_mux.sv
// Self-checking bench for arb_pkt_mux with a round-robin arbiter stand-in and packet scoreboard.
module tb_arb_pkt_mux;
  localparam int N       = 3;
  localparam int W       = 8;
  localparam int TIMEOUT = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   s_valid, s_ready, s_last;
  logic [N*W-1:0] s_data;
  logic [N-1:0]   arb_req, arb_gnt;
  logic           arb_upd, m_valid, m_ready, m_last, err_to;
  logic [W-1:0]   m_data;

  always #5 clk = ~clk;

  arb_pkt_mux #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .arb_req(arb_req), .arb_gnt(arb_gnt), .arb_upd(arb_upd),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err_to(err_to)
  );

  // Round-robin arbiter stand-in: lowest distance from ptr wins; upd moves ptr past the winner.
  int ptr;
  always_comb begin
    int best;
    best    = N;
    arb_gnt = '0;
    for (int i = 0; i < N; i++)
      if (arb_req[i] && ((i - ptr + N) % N) < best) best = (i - ptr + N) % N;
    for (int i = 0; i < N; i++)
      if (arb_req[i] && ((i - ptr + N) % N) == best) arb_gnt[i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr <= 0;
    else if (arb_upd)
      for (int i = 0; i < N; i++)
        if (arb_gnt[i]) ptr <= (i + 1) % N;
  end

  int n_tests, n_fail;
  logic [8:0] srcq [N][$];
  logic [8:0] expq [N][$];
  logic       mr_pat [$];
  bit         rnd_rdy;
  int         mptr, cur_src, beats_out, pkts_out, upd_cnt, stall_cnt, pkt_id;
  logic [N-1:0] acc_mask;
  logic       prev_stall, prev_last;
  logic [W-1:0] prev_data;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [N-1:0] v, input int src, input logic [7:0] d, input logic l);
    s_valid = v;
    s_data  = '0;
    s_last  = '0;
    s_data[src*W +: W] = d;
    s_last[src] = l;
  endtask

  // Beat encoding: {last, src[1:0], pkt[2:0], beat[2:0]}.
  task automatic add_pkt(input int src, input int len);
    logic [8:0] b;
    for (int k = 0; k < len; k++) begin
      b = {(k == len - 1), 2'(src), 3'(pkt_id), 3'(k)};
      srcq[src].push_back(b);
      expq[src].push_back(b);
    end
    pkt_id++;
  endtask

  function automatic int exp_next();
    for (int k = 0; k < N; k++)
      if (expq[(mptr + k) % N].size() > 0) return (mptr + k) % N;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (srcq[i].size() > 0 || expq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        s_valid[i] = 1'b1;
        s_data[i*W +: W] = srcq[i][0][7:0];
        s_last[i] = srcq[i][0][8];
      end else begin
        s_valid[i] = 1'b0;
        s_data[i*W +: W] = '0;
        s_last[i] = 1'b0;
      end
    end
    if (mr_pat.size() > 0) m_ready = mr_pat.pop_front();
    else if (rnd_rdy)      m_ready = ($urandom_range(3) != 0);
    else                   m_ready = 1'b1;
  endtask

  task automatic monitor();
    int src;
    logic [8:0] e;
    if (prev_stall) begin
      chk("stall_data", 32'(m_data), 32'(prev_data));
      chk("stall_last", 32'(m_last), 32'(prev_last));
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    if (prev_stall) begin
      stall_cnt++;
      chk("bp_sready", 32'(s_ready), 0);
    end
    chk("sready_onehot0", 32'($onehot0(s_ready)), 1);
    acc_mask = s_valid & s_ready;
    if (arb_upd) upd_cnt++;
    if (m_valid && m_ready) begin
      src = int'(m_data[7:6]);
      beats_out++;
      if (cur_src < 0) begin
        chk("pkt_order", src, exp_next());
        cur_src = src;
      end else begin
        chk("no_interleave", src, cur_src);
      end
      chk("beat_pending", 32'(src < N && expq[src].size() > 0), 1);
      if (src < N && expq[src].size() > 0) begin
        e = expq[src].pop_front();
        chk("beat", 32'({m_last, m_data}), 32'(e));
      end
      if (m_last) begin
        cur_src = -1;
        mptr = (src + 1) % N;
        pkts_out++;
      end
    end
  endtask

  task automatic run(input int max_cyc, input int stop_beats);
    int cyc;
    bit fin;
    cyc = 0;
    fin = 1'b0;
    prev_stall = 1'b0;
    drive();
    while (!fin && cyc < max_cyc) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (acc_mask[i] && srcq[i].size() > 0) srcq[i].delete(0);
      drive();
      cyc++;
      if (stop_beats > 0) fin = (beats_out >= stop_beats);
      else                fin = all_empty() && !m_valid && cur_src < 0;
    end
    chk("run_done", 32'(fin), 1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      expq[i].delete();
    end
    mptr = 0;
    cur_src = -1;
  endtask

  initial begin
    int k, u0, p0, st0, b0;
    bit seen;
    n_tests = 0; n_fail = 0; rnd_rdy = 1'b0; pkt_id = 0;
    beats_out = 0; pkts_out = 0; upd_cnt = 0; stall_cnt = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; acc_mask = '0;
    clear_model();

    // Reset with every source requesting
    rstn = 1'b0; s_valid = '1; s_data = '0; s_last = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data",  32'(m_data), 0);
    chk("rst_m_last",  32'(m_last), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_arb_req", 32'(arb_req), 0);
    chk("rst_arb_upd", 32'(arb_upd), 0);
    chk("rst_err_to",  32'(err_to), 0);
    s_valid = '0; rstn = 1'b1;
    @(posedge clk); #1;

    // Single source: 0x11, 0x12, 0x13(last) from source 1
    drv(3'b010, 1, 8'h11, 1'b0);
    @(negedge clk);
    chk("ss_req_idle", 32'(arb_req), 32'h2);
    chk("ss_ready_idle", 32'(s_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ss_ready_lock", 32'(s_ready), 32'h2);
    chk("ss_upd_b0", 32'(arb_upd), 0);
    @(posedge clk); #1;
    drv(3'b010, 1, 8'h12, 1'b0);
    @(negedge clk);
    chk("ss_out0", 32'({m_valid, m_last, m_data}), 32'h211);
    chk("ss_upd_b1", 32'(arb_upd), 0);
    @(posedge clk); #1;
    drv(3'b010, 1, 8'h13, 1'b1);
    @(negedge clk);
    chk("ss_out1", 32'({m_valid, m_last, m_data}), 32'h212);
    chk("ss_upd_last", 32'(arb_upd), 1);
    @(posedge clk); #1;
    drv(3'b000, 1, 8'h00, 1'b0);
    @(negedge clk);
    chk("ss_out2", 32'({m_valid, m_last, m_data}), 32'h313);
    chk("ss_idle_req", 32'(arb_req), 0);
    chk("ss_upd_after", 32'(arb_upd), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ss_drained", 32'(m_valid), 0);
    @(posedge clk); #1;

    // Contention: after source 1's packet the rotation resumes at source 2
    mptr = 2;
    u0 = upd_cnt; p0 = pkts_out;
    add_pkt(0, 2); add_pkt(1, 2); add_pkt(2, 2);
    run(200, 0);
    chk("cont_upd", upd_cnt - u0, 3);
    chk("cont_pkts", pkts_out - p0, 3);

    // Back-pressure during a 4-beat packet from source 2
    u0 = upd_cnt; p0 = pkts_out; st0 = stall_cnt;
    mr_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    add_pkt(2, 4);
    run(200, 0);
    chk("bp_pkts", pkts_out - p0, 1);
    chk("bp_upd", upd_cnt - u0, 1);
    chk("bp_stalls", stall_cnt - st0, 2);

    // Reset after 2 of 4 beats have drained
    b0 = beats_out;
    add_pkt(0, 4);
    run(200, b0 + 2);
    rstn = 1'b0;
    #1;
    chk("mr_m_valid", 32'(m_valid), 0);
    chk("mr_s_ready", 32'(s_ready), 0);
    chk("mr_arb_req", 32'(arb_req), 0);
    clear_model();
    s_valid = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    p0 = pkts_out; u0 = upd_cnt;
    add_pkt(1, 3);
    run(200, 0);
    chk("mr_new_pkts", pkts_out - p0, 1);
    chk("mr_new_upd", upd_cnt - u0, 1);

    // Source 0 stalls after one non-last beat
    drv(3'b001, 0, 8'h5a, 1'b0);
    m_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wd_sready", 32'(s_ready), 32'h1);
    @(posedge clk); #1;
    drv(3'b000, 0, 8'h00, 1'b0);
`ifdef ARB_PKT_MUX_TIMEOUT_EN
    k = 0; seen = 1'b0;
    for (int c = 1; c <= 3 * TIMEOUT + 4 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) chk("wd_beat", 32'({m_valid, m_data}), 32'h15a);
      if (arb_upd) begin
        seen = 1'b1;
        k = c;
      end
      @(posedge clk); #1;
    end
    chk("wd_release_cycle", k, TIMEOUT + 1);
    u0 = upd_cnt;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (arb_upd) upd_cnt++;
      @(posedge clk); #1;
    end
    chk("wd_single_pulse", upd_cnt - u0, 0);
    chk("wd_err_to", 32'(err_to), 1);
    chk("wd_idle_req", 32'(arb_req), 0);
`else
    u0 = upd_cnt;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) chk("lk_beat", 32'({m_valid, m_data}), 32'h15a);
      if (arb_upd) upd_cnt++;
      @(posedge clk); #1;
    end
    chk("lk_no_upd", upd_cnt - u0, 0);
    chk("lk_held", 32'(arb_req), 32'h1);
    chk("lk_err_to", 32'(err_to), 0);
    drv(3'b001, 0, 8'h5b, 1'b1);
    @(negedge clk);
    chk("lk_release_upd", 32'(arb_upd), 1);
    @(posedge clk); #1;
    drv(3'b000, 0, 8'h00, 1'b0);
    @(negedge clk);
    chk("lk_idle_req", 32'(arb_req), 0);
    @(posedge clk); #1;
`endif

    // Randomized packets with random back-pressure from a fresh reset
    rstn = 1'b0;
    #1;
    chk("rr_err_cleared", 32'(err_to), 0);
    clear_model();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    p0 = pkts_out; u0 = upd_cnt;
    rnd_rdy = 1'b1;
    for (int r = 0; r < 8; r++) add_pkt(int'($urandom_range(N - 1)), int'($urandom_range(4, 1)));
    run(3000, 0);
    chk("rnd_pkts", pkts_out - p0, 8);
    chk("rnd_upd", upd_cnt - u0, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
